// File: rtl/adc_3wire_master.sv
// 3-wire serial configuration master for the KATADC: shifts {12'h001, addr, data} MSB first.
// Optional frame counter enabled by defining ADC3WIRE_FRAME_COUNT_EN.
module adc_3wire_master #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        config_start,
   input  logic [3:0]  config_addr,
   input  logic [15:0] config_data,
   output logic        config_done,
   output logic        busy,
   output logic        adc_scs_n,
   output logic        adc_sclk,
   output logic        adc_sdata,
   output logic [15:0] frame_count
);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      HOLD,
      GAP,
      DONE
   } state_t;

   localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
   localparam logic [8:0] BIT_LAST  = 9'(2 * CLK_DIV - 1);
   localparam logic [8:0] SCLK_HIGH = 9'(CLK_DIV);
   localparam logic [8:0] GAP_LAST  = 9'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [8:0]  cnt_inc;
   logic [4:0]  bit_q, bit_d;
   logic [31:0] shreg_q, shreg_d;
   logic        sclk_d, sdata_d, scs_n_d, done_d, busy_d;

   assign cnt_inc = cnt_q + 9'd1;

   // Next-state and next-pin logic; every pin is registered from these values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sclk_d  = adc_sclk;
      sdata_d = adc_sdata;
      scs_n_d = adc_scs_n;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (config_start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               bit_d   = 5'd31;
               shreg_d = {12'h001, config_addr, config_data};
               sdata_d = 1'b0;
               sclk_d  = 1'b0;
               scs_n_d = 1'b0;
            end
         end
         SHIFT: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d  = '0;
               sclk_d = 1'b0;
               if (bit_q == 5'd0) begin
                  state_d = HOLD;
                  sdata_d = 1'b0;
               end else begin
                  bit_d   = bit_q - 5'd1;
                  shreg_d = {shreg_q[30:0], 1'b0};
                  sdata_d = shreg_q[30];
               end
            end else begin
               cnt_d  = cnt_inc;
               sclk_d = (cnt_inc >= SCLK_HIGH);
            end
         end
         HOLD: begin
            if (cnt_q == HALF_LAST) begin
               state_d = GAP;
               cnt_d   = '0;
               scs_n_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            scs_n_d = 1'b1;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         adc_scs_n   <= 1'b1;
         adc_sclk    <= 1'b0;
         adc_sdata   <= 1'b0;
         config_done <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         adc_scs_n   <= scs_n_d;
         adc_sclk    <= sclk_d;
         adc_sdata   <= sdata_d;
         config_done <= done_d;
         busy        <= busy_d;
      end
   end

`ifdef ADC3WIRE_FRAME_COUNT_EN
   logic [15:0] frame_cnt_q;

   // Counts completed frames; wraps naturally and is cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else if (config_done) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_count = frame_cnt_q;
`else
   assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_adc_3wire_master.sv
// Self-checking bench for adc_3wire_master: instance A (H=2, G=4) and instance B (H=1, G=3).
module tb_adc_3wire_master;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        startA, startB;
   logic [3:0]  addrA, addrB;
   logic [15:0] dataA, dataB;
   logic        doneA, busyA, scsA, sclkA, sdataA;
   logic        doneB, busyB, scsB, sclkB, sdataB;
   logic [15:0] fcA, fcB;

   adc_3wire_master #(.CLK_DIV(2), .GAP_CYCLES(4)) dutA (
      .clk(clk), .rst(rst), .config_start(startA), .config_addr(addrA), .config_data(dataA),
      .config_done(doneA), .busy(busyA), .adc_scs_n(scsA), .adc_sclk(sclkA), .adc_sdata(sdataA),
      .frame_count(fcA)
   );

   adc_3wire_master #(.CLK_DIV(1), .GAP_CYCLES(3)) dutB (
      .clk(clk), .rst(rst), .config_start(startB), .config_addr(addrB), .config_data(dataB),
      .config_done(doneB), .busy(busyB), .adc_scs_n(scsB), .adc_sclk(sclkB), .adc_sdata(sdataB),
      .frame_count(fcB)
   );

   typedef struct {
      logic [3:0]  a;
      logic [15:0] d;
      logic [31:0] f;
   } vec_t;

   vec_t vecs[9];
   int   total = 0;
   int   bad = 0;
   int   expCount = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic getPins(input bit sel, output logic scs, output logic sclk, output logic sdata,
                          output logic done, output logic bsy);
      scs   = sel ? scsB   : scsA;
      sclk  = sel ? sclkB  : sclkA;
      sdata = sel ? sdataB : sdataA;
      done  = sel ? doneB  : doneA;
      bsy   = sel ? busyB  : busyA;
   endtask

   task automatic driveReq(input bit sel, input logic s, input logic [3:0] a, input logic [15:0] d);
      if (sel) begin
         startB = s; addrB = a; dataB = d;
      end else begin
         startA = s; addrA = a; dataA = d;
      end
   endtask

   // One request; n counts cycles after the accepting edge k (n=1 is cycle k+1).
   task automatic applyStimulus(input bit sel, input int h, input int g, input logic [3:0] a,
                                input logic [15:0] d, input logic [31:0] expFrame,
                                input bit collide, input int abortAt);
      logic [31:0] cap;
      int          rises, lowCnt, gapCnt, doneN, doneCnt, unstable, idleBad;
      logic        scs, sclk, sdata, done, bsy, prevSclk, prevSdata;
      bit          finished, aborted;
      cap = '0; rises = 0; lowCnt = 0; gapCnt = 0; doneN = 0; doneCnt = 0;
      unstable = 0; idleBad = 0; finished = 0; aborted = 0;
      prevSclk = 1'b0; prevSdata = 1'b0;
      @(negedge clk);
      driveReq(sel, 1'b1, a, d);
      @(negedge clk);
      driveReq(sel, 1'b0, a, d);
      for (int n = 1; n <= 1000 && !finished; n++) begin
         if (n > 1) @(negedge clk);
         getPins(sel, scs, sclk, sdata, done, bsy);
         if (abortAt != 0 && n == abortAt) begin
            rst = 1'b1;
            #1;
            getPins(sel, scs, sclk, sdata, done, bsy);
            checkOutput("abort_pins", {28'd0, scs, sclk, sdata, bsy}, 32'h8);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               getPins(sel, scs, sclk, sdata, done, bsy);
               if (done) doneCnt++;
            end
            checkOutput("abort_no_done", doneCnt, 0);
            rst = 1'b0;
            finished = 1;
            aborted = 1;
            expCount = 0;
         end else begin
            if (!scs) lowCnt++;
            else if (bsy && !done) gapCnt++;
            if (sclk && !prevSclk) begin
               cap = {cap[30:0], sdata};
               rises++;
               if (sdata !== prevSdata) unstable++;
            end
            prevSclk = sclk;
            prevSdata = sdata;
            if (collide && n == 10) driveReq(sel, 1'b1, ~a, ~d);
            if (collide && n == 11) driveReq(sel, 1'b0, ~a, ~d);
            if (done) begin
               doneCnt++;
               doneN = n;
               finished = 1;
               if (collide) driveReq(sel, 1'b1, ~a, 16'h5A5A);
            end
         end
      end
      if (!aborted) begin
         checkOutput("frame_bits", cap, expFrame);
         checkOutput("sclk_rises", rises, 32);
         checkOutput("scs_low_cycles", lowCnt, 65 * h);
         checkOutput("gap_high_cycles", gapCnt, g);
         checkOutput("done_cycle", doneN, 65 * h + g + 1);
         checkOutput("sdata_stable", unstable, 0);
         if (!sel) expCount++;
         if (collide) begin
            @(negedge clk);
            driveReq(sel, 1'b0, a, d);
            for (int i = 0; i < 6; i++) begin
               getPins(sel, scs, sclk, sdata, done, bsy);
               if (!scs || bsy || done) idleBad++;
               @(negedge clk);
            end
            checkOutput("collide_ignored", idleBad, 0);
         end
      end
   endtask

   initial begin
      vecs[0] = '{4'h0, 16'h7FFF, 32'h00107FFF};
      vecs[1] = '{4'h1, 16'hBAFF, 32'h0011BAFF};
      vecs[2] = '{4'h2, 16'h007F, 32'h0012007F};
      vecs[3] = '{4'h3, 16'h0BFF, 32'h00130BFF};
      vecs[4] = '{4'h9, 16'h23FF, 32'h001923FF};
      vecs[5] = '{4'hA, 16'h1234, 32'h001A1234};
      vecs[6] = '{4'hB, 16'h0000, 32'h001B0000};
      vecs[7] = '{4'hE, 16'h8000, 32'h001E8000};
      vecs[8] = '{4'hF, 16'h007F, 32'h001F007F};

      rst = 1'b1;
      startA = 1'b0; addrA = '0; dataA = '0;
      startB = 1'b0; addrB = '0; dataB = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_pins_A", {28'd0, scsA, sclkA, sdataA, busyA}, 32'h8);
      checkOutput("reset_done_A", {31'd0, doneA}, 0);
      checkOutput("reset_count_A", {16'd0, fcA}, 0);
      checkOutput("reset_pins_B", {28'd0, scsB, sclkB, sdataB, busyB}, 32'h8);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(1'b0, 2, 4, 4'h9, 16'h23FF, 32'h001923FF, 1'b0, 0);
      applyStimulus(1'b0, 2, 4, 4'hA, 16'h1234, 32'h001A1234, 1'b1, 0);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expCount = 0;
      for (int i = 0; i < 9; i++)
         applyStimulus(1'b0, 2, 4, vecs[i].a, vecs[i].d, vecs[i].f, 1'b0, 0);
      @(negedge clk);
`ifdef ADC3WIRE_FRAME_COUNT_EN
      checkOutput("frame_count_9", {16'd0, fcA}, 9);
`else
      checkOutput("frame_count_tied", {16'd0, fcA}, 0);
`endif

      applyStimulus(1'b0, 2, 4, 4'h5, 16'hFFFF, 32'h0015FFFF, 1'b0, 40);
      checkOutput("after_abort_count", {16'd0, fcA}, 0);
      applyStimulus(1'b0, 2, 4, 4'h1, 16'hBAFF, 32'h0011BAFF, 1'b0, 0);

      applyStimulus(1'b1, 1, 3, 4'h9, 16'h23FF, 32'h001923FF, 1'b0, 0);
      applyStimulus(1'b1, 1, 3, 4'hE, 16'h8000, 32'h001E8000, 1'b0, 0);
      applyStimulus(1'b1, 1, 3, 4'h0, 16'h7FFF, 32'h00107FFF, 1'b0, 0);

`ifdef ADC3WIRE_FRAME_COUNT_EN
      @(negedge clk);
      force dutA.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dutA.frame_cnt_q;
      @(negedge clk);
      checkOutput("preload_ffff", {16'd0, fcA}, 32'h0000FFFF);
      applyStimulus(1'b0, 2, 4, 4'h3, 16'h0BFF, 32'h00130BFF, 1'b0, 0);
      @(negedge clk);
      checkOutput("wrap_to_zero", {16'd0, fcA}, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_3wire_master.md
# adc_3wire_master

Serial configuration engine for the KATADC board. Accepts one 4-bit address / 16-bit data word per request on the `config_*` handshake, from the power-up auto-configuration sequencer or the OPB register path, and shifts it into the ADC's 3-wire serial port. It drives the ADC's chip select, serial clock and serial data pins, then returns a single-cycle `config_done` when the frame and inter-frame gap are complete.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles (H); legal range 1..255.
- `GAP_CYCLES`, default 8: minimum cycles chip select is held high after a frame (G); legal range 1..255.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `config_start` in 1: request pulse; sampled only in IDLE.
- `config_addr` in 4: register address; captured when `config_start` is accepted.
- `config_data` in 16: register data; captured with `config_addr`.
- `config_done` out 1: one-cycle pulse when the frame and gap are complete.
- `busy` out 1: high from acceptance through the `config_done` cycle inclusive.
- `adc_scs_n` out 1: ADC chip select, active low.
- `adc_sclk` out 1: ADC serial clock.
- `adc_sdata` out 1: ADC serial data, MSB first.
- `frame_count` out 16: count of completed frames (see Configuration).

## Operation
- Frame is 32 bits, sent MSB first: {12'h001, addr[3:0], data[15:0]}.
- States and transitions:
  - IDLE to SHIFT when `config_start` is high. At that edge, addr/data are latched into a 32-bit shift register.
  - SHIFT: 32 bits, each occupying 2H cycles. `sclk` is low for the first H cycles and high for the next H. `sdata` changes only at the start of the low phase. The ADC samples on the rising `sclk` edge.
  - SHIFT to HOLD after the high phase of bit 0. In HOLD, `sclk`=0, `scs_n`=0, `sdata`=0, for H cycles.
  - HOLD to GAP. In GAP, `scs_n`=1, for G cycles.
  - GAP to DONE. DONE lasts one cycle with `config_done`=1, then returns to IDLE.
- `config_start` is ignored in every state except IDLE, including the DONE cycle. Inputs are not re-sampled during a frame.
- All pin outputs are registered, with no combinational path from inputs to pins.
- Reset values: `adc_scs_n`=1, `adc_sclk`=0, `adc_sdata`=0, `busy`=0, `config_done`=0, `frame_count`=0, state=IDLE.
- Reset asserted mid-frame aborts the frame immediately and asynchronously. No `config_done` is issued. The next request after reset release sends a full frame.

## Timing
- Let `config_start` be sampled high at edge k.
- `adc_scs_n` is low during cycles k+1 .. k+65H.
- Bit 31 is valid from cycle k+1. Bit i is valid from cycle k+1+(31−i)·2H and held for 2H cycles.
- The `sclk` rising edge for bit i occurs at cycle k+1+(31−i)·2H+H.
- `adc_scs_n` is high from cycle k+65H+1.
- `config_done` is high in exactly cycle k+65H+G+1.
- A new request is accepted from cycle k+65H+G+2 onward.
- Throughput: one frame per 65H+G+2 cycles when requests are back-to-back.
- Counters are sized to hold 2H−1 and G−1 without overflow. The bit counter is 5 bits and terminates at bit 0, with no wrap.

## Configuration
- `ADC3WIRE_FRAME_COUNT_EN` defined: `frame_count` increments by 1 in each `config_done` cycle and wraps from 16'hFFFF to 16'h0000. It is cleared only by `rst`.
- Not defined: the counter is not built and `frame_count` is tied to 16'h0000.

## Test plan
- Single write with H=2, G=4, addr=4'h9, data=16'h23FF, start at edge k:
  - The bits sampled on the 32 `sclk` rises equal 32'h001923FF.
  - `scs_n` is low for cycles k+1..k+130.
  - `config_done` occurs in cycle k+135 only.
- Busy collision: pulse `config_start` again at k+10 and in the DONE cycle. Both are ignored: exactly one frame and one `config_done`, and the captured data is unchanged.
- Back-to-back sequence of the 9 power-up writes (0x0/7FFF … 0xF/007F), each issued one cycle after `config_done`:
  - There are 9 frames with correct contents.
  - `scs_n` is high for at least G cycles between frames.
  - `frame_count`=9 when the macro is defined, and 0 when it is not.
- Reset mid-frame: assert `rst` at cycle k+40.
  - The pins go to 1/0/0 asynchronously, with no `config_done`.
  - After release, a new request for addr 4'h1 / data 16'hBAFF shifts 32'h0011BAFF correctly.
- H=1 corner: each bit is 2 cycles. `config_done` occurs at k+65+G+1, and `sdata` is stable around every `sclk` rise.
- Counter wrap with the macro defined: preload via 65535 frames (or force) and send one more. `frame_count` goes from 16'hFFFF to 16'h0000.
